// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time, presents it to the
// control decoder, and selects the next PC from the returned Branch/Zero/Jump outcome.
`timescale 1ns/1ps

module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              Branch,
   input  logic              Zero,
   input  logic              Jump,
   output logic [31:0]       instr,
   output logic [5:0]        Opcode,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              halted,
   output logic [31:0]       retire_cnt
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] branch_off;
   logic [ADDR_W-1:0] next_pc;
   logic [31:0]       instr_q;
   logic [31:0]       retire_q;
   logic              fetch_done;
   logic              retire;

   // Opcodes the single-cycle decoder implements; anything else traps to HALT.
   function automatic logic opcode_legal(input logic [5:0] op);
      case (op)
         6'b000000, 6'b001000, 6'b100011, 6'b101011,
         6'b001100, 6'b000100, 6'b000011: opcode_legal = 1'b1;
         default:                         opcode_legal = 1'b0;
      endcase
   endfunction

   assign fetch_done = (state == FETCH) && imem_ready;
   assign retire     = (state == HOLD) && !stall;

   // ---------------------------------------------------------------- state register
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   // ---------------------------------------------------------------- next-state logic
   // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   if (imem_ready) state_nxt = opcode_legal(imem_rdata[31:26]) ? HOLD : HALT;
         HOLD:    if (!stall)     state_nxt = FETCH;
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
   end

   // ---------------------------------------------------------------- output logic
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      halted      = 1'b0;
      case (state)
         FETCH:   imem_req    = 1'b1;
         HOLD:    instr_valid = 1'b1;
         HALT:    halted      = 1'b1;
         default: imem_req    = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------- next PC selection
   assign pc_inc     = pc + ADDR_W'(4);
   assign branch_off = {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};

   always_comb begin
      next_pc = pc_inc;
      if (Jump)                next_pc = {pc_inc[ADDR_W-1:ADDR_W-4], instr_q[25:0], 2'b00};
      else if (Branch && Zero) next_pc = pc_inc + branch_off;
   end

   // ---------------------------------------------------------------- datapath registers
   // PC only moves at retire, so in HALT it still names the faulting word.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= {RESET_PC[ADDR_W-1:2], 2'b00};
         instr_q  <= 32'h0;
         retire_q <= 32'h0;
      end else begin
         if (fetch_done) instr_q <= imem_rdata;
         if (retire) begin
            pc       <= next_pc;
            retire_q <= retire_q + 32'd1;
         end
      end
   end

   assign imem_addr  = pc;
   assign pc_out     = pc;
   assign pc_plus4   = pc_inc;
   assign instr      = instr_q;
   assign Opcode     = instr_q[31:26];
   assign retire_cnt = retire_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a transaction-level reference model checked every
// cycle, plus directed sequences with hand-computed fetch addresses and counts.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        Branch, Zero, Jump;
   logic [31:0] instr;
   logic [5:0]  Opcode;
   logic        instr_valid;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        halted;
   logic [31:0] retire_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [logic [31:0]];

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .Branch      (Branch),
      .Zero        (Zero),
      .Jump        (Jump),
      .instr       (instr),
      .Opcode      (Opcode),
      .instr_valid (instr_valid),
      .pc_out      (pc_out),
      .pc_plus4    (pc_plus4),
      .halted      (halted),
      .retire_cnt  (retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if ($isunknown(a))   return 32'h0;
      if (mem.exists(a))   return mem[a];
      return 32'h0;
   endfunction

   // Present the word at the current address, then advance to the next falling edge.
   task automatic tick();
      imem_rdata = mem_word(imem_addr);
      @(negedge clk);
   endtask

   // ------------------------------------------------------------ reference model
   // Tracks what the fetch unit is doing at the instruction level: which address it is on,
   // whether an instruction is being presented, whether it has trapped, and how many retired.
   logic [31:0] m_pc, m_instr, m_cnt;
   logic        m_presenting, m_trapped;
   bit          chk_en = 0;

   function automatic bit supported(input logic [31:0] w);
      return w[31:26] inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h0C, 6'h04, 6'h03};
   endfunction

   function automatic logic [31:0] target(input logic [31:0] pc, input logic [31:0] w,
                                          input logic j, input logic b, input logic z);
      logic [31:0] link;
      int          off;
      link = pc + 32'd4;
      off  = int'($signed(w[15:0])) * 4;
      if (j)          return (link & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
      else if (b & z) return link + 32'(off);
      else            return link;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
         m_presenting = 1'b0; m_trapped = 1'b0;
         chk_en = 1;
      end else if (m_trapped) begin
         // only reset leaves a trap
      end else if (!m_presenting) begin
         if (imem_ready) begin
            m_instr = imem_rdata;
            if (supported(imem_rdata)) m_presenting = 1'b1;
            else                       m_trapped    = 1'b1;
         end
      end else if (!stall) begin
         m_pc = target(m_pc, m_instr, Jump, Branch, Zero);
         m_cnt = m_cnt + 32'd1;
         m_presenting = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model imem_req",    {31'h0, imem_req},    {31'h0, !m_presenting && !m_trapped});
         check("model imem_addr",   imem_addr,            m_pc);
         check("model instr_valid", {31'h0, instr_valid}, {31'h0, m_presenting});
         check("model instr",       instr,                m_instr);
         check("model Opcode",      {26'h0, Opcode},      {26'h0, m_instr[31:26]});
         check("model pc_out",      pc_out,               m_pc);
         check("model pc_plus4",    pc_plus4,             m_pc + 32'd4);
         check("model halted",      {31'h0, halted},      {31'h0, m_trapped});
         check("model retire_cnt",  retire_cnt,           m_cnt);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ directed stimulus
   initial begin
      reset = 1'b1; imem_ready = 1'b1; stall = 1'b0;
      Branch = 1'b0; Zero = 1'b0; Jump = 1'b0; imem_rdata = 32'h0;
      mem[32'h10] = 32'h1000_0003;   // beq +3
      mem[32'h14] = 32'h0C00_0004;   // jal 0x10
      mem[32'h20] = 32'h0C00_0004;   // jal 0x10
      mem[32'h40] = 32'h0C00_0100;   // jal 0x400
      tick(); tick();
      reset = 1'b0;

      // Reset state
      check("rst imem_req",    {31'h0, imem_req},    32'h1);
      check("rst imem_addr",   imem_addr,            32'h0);
      check("rst instr_valid", {31'h0, instr_valid}, 32'h0);
      check("rst halted",      {31'h0, halted},      32'h0);
      check("rst retire_cnt",  retire_cnt,           32'h0);
      check("rst instr",       instr,                32'h0);

      // Straight-line R-type code, two cycles per instruction
      for (int i = 0; i < 3; i++) begin
         check("seq fetch addr", imem_addr, 32'(4 * i));
         check("seq fetch valid", {31'h0, instr_valid}, 32'h0);
         tick();
         check("seq hold valid", {31'h0, instr_valid}, 32'h1);
         check("seq hold pc_out", pc_out, 32'(4 * i));
         tick();
      end
      check("seq retire_cnt", retire_cnt, 32'd3);
      check("seq next addr", imem_addr, 32'h0C);

      tick(); tick();
      check("beq fetch addr", imem_addr, 32'h10);
      Branch = 1'b1; Zero = 1'b1;
      tick();
      check("beq Opcode", {26'h0, Opcode}, 32'h04);
      check("beq pc_plus4", pc_plus4, 32'h14);
      tick();
      check("beq taken addr", imem_addr, 32'h20);

      Branch = 1'b0; Zero = 1'b0; Jump = 1'b1;
      tick(); tick();
      check("jal back addr", imem_addr, 32'h10);
      Jump = 1'b0; Branch = 1'b1; Zero = 1'b0;
      tick(); tick();
      check("beq not-taken addr", imem_addr, 32'h14);

      Branch = 1'b0; Jump = 1'b1;
      mem[32'h10] = 32'h1000_FFFE;   // beq -2
      tick(); tick();
      check("jal back addr 2", imem_addr, 32'h10);
      Jump = 1'b0; Branch = 1'b1; Zero = 1'b1;
      tick(); tick();
      check("beq backward addr", imem_addr, 32'h0C);

      mem[32'h0C] = 32'h0C00_0010;   // jal 0x40
      Branch = 1'b0; Zero = 1'b0; Jump = 1'b1;
      tick(); tick();
      check("jal to 0x40 addr", imem_addr, 32'h40);
      Branch = 1'b1; Zero = 1'b1; Jump = 1'b1;
      tick();
      check("jal pc_out", pc_out, 32'h40);
      check("jal pc_plus4", pc_plus4, 32'h44);
      tick();
      check("jump over branch addr", imem_addr, 32'h400);
      Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;

      // Memory wait, then downstream stall
      imem_ready = 1'b0;
      repeat (5) begin
         tick();
         check("wait addr stable", imem_addr, 32'h400);
         check("wait req", {31'h0, imem_req}, 32'h1);
         check("wait valid", {31'h0, instr_valid}, 32'h0);
      end
      imem_ready = 1'b1;
      tick();
      check("pre-stall retire_cnt", retire_cnt, 32'd11);
      stall = 1'b1;
      repeat (3) begin
         tick();
         check("stall valid", {31'h0, instr_valid}, 32'h1);
         check("stall pc_out", pc_out, 32'h400);
         check("stall instr", instr, 32'h0);
         check("stall retire_cnt", retire_cnt, 32'd11);
      end
      stall = 1'b0;
      tick();
      check("post-stall retire_cnt", retire_cnt, 32'd12);
      check("post-stall addr", imem_addr, 32'h404);

      // Reset on the same edge as imem_ready
      mem[32'h404] = 32'h2000_0005;
      mem[32'h8]   = 32'hFC00_0000;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid-fetch rst valid", {31'h0, instr_valid}, 32'h0);
      check("mid-fetch rst addr", imem_addr, 32'h0);
      check("mid-fetch rst instr", instr, 32'h0);
      check("mid-fetch rst retire_cnt", retire_cnt, 32'h0);

      // Illegal opcode at 0x8
      repeat (5) tick();
      check("halt halted", {31'h0, halted}, 32'h1);
      check("halt pc_out", pc_out, 32'h8);
      check("halt instr", instr, 32'hFC00_0000);
      check("halt Opcode", {26'h0, Opcode}, 32'h3F);
      check("halt retire_cnt", retire_cnt, 32'd2);
      repeat (4) begin
         tick();
         check("halt req low", {31'h0, imem_req}, 32'h0);
         check("halt stays", {31'h0, halted}, 32'h1);
      end

      // Reset out of HALT, then branch to the top of the address space and wrap
      mem[32'h0] = 32'h1000_FFFE;
      Branch = 1'b1; Zero = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("unhalt halted", {31'h0, halted}, 32'h0);
      check("unhalt addr", imem_addr, 32'h0);
      tick(); tick();
      check("wrap fetch addr", imem_addr, 32'hFFFF_FFFC);
      Branch = 1'b0; Zero = 1'b0;
      tick();
      check("wrap pc_out", pc_out, 32'hFFFF_FFFC);
      check("wrap pc_plus4", pc_plus4, 32'h0);
      tick();
      check("wrap next addr", imem_addr, 32'h0);
      check("wrap req", {31'h0, imem_req}, 32'h1);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
